// File: rtl/prio_encoder_hs_pkg.sv
// prio_encoder_hs_pkg: shared FSM state type and default request width for prio_encoder_hs.
package prio_encoder_hs_pkg;
   localparam int N_IN_DEF = 8;
   typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;
endpackage

// File: rtl/prio_encoder_hs_pick.sv
// prio_pick: combinational rotating find-first-set, scanning upward from start and wrapping.
module prio_pick
   import prio_encoder_hs_pkg::*;
#(
   parameter int N_IN = N_IN_DEF,
   localparam int IDX_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  vec,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             found
);
   // Scan offsets from farthest to nearest so the nearest set bit is written last.
   always_comb begin
      idx = '0;
      found = 1'b0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         int j;
         j = int'(start) + i;
         if (j >= N_IN) j = j - N_IN;
         if (vec[j]) begin
            found = 1'b1;
            idx = IDX_W'(j);
         end
      end
   end
endmodule

// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs: registered priority encoder with request capture and valid/ready output.
// Define ROUND_ROBIN_EN for a rotating start pointer; otherwise bit 0 has fixed highest priority.
module prio_encoder_hs
   import prio_encoder_hs_pkg::*;
#(
   parameter int N_IN = N_IN_DEF,
   localparam int IDX_W = $clog2(N_IN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IN-1:0]  req_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [N_IN-1:0]  out_onehot,
   output logic [N_IN-1:0]  pend_o
);
   state_t           state;
   logic [N_IN-1:0]  pend;
   logic [N_IN-1:0]  clr;
   logic [N_IN-1:0]  sel_vec;
   logic [IDX_W-1:0] start_ptr;
   logic [IDX_W-1:0] pick_idx;
   logic             found;
   logic             acc;

   assign acc = out_valid & out_ready;
   assign clr = acc ? N_IN'(1) << out_idx : '0;
   assign sel_vec = pend & ~clr;
   assign pend_o = pend;
   assign out_onehot = out_valid ? N_IN'(1) << out_idx : '0;

`ifdef ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr;
   // The rotated value is used by a reload in the same edge as the accept.
   assign start_ptr = acc ? (out_idx == IDX_W'(N_IN - 1) ? '0 : out_idx + 1'b1) : rr_ptr;
   always_ff @(posedge clk or posedge rst)
      if (rst) rr_ptr <= '0;
      else rr_ptr <= start_ptr;
`else
   assign start_ptr = '0;
`endif

   prio_pick #(.N_IN(N_IN)) u_pick (
      .vec  (sel_vec),
      .start(start_ptr),
      .idx  (pick_idx),
      .found(found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
         out_valid <= 1'b0;
         out_idx <= '0;
         state <= ST_IDLE;
      end else begin
         pend <= sel_vec | req_i;
         if (state == ST_IDLE) begin
            if (found) begin
               out_idx <= pick_idx;
               out_valid <= 1'b1;
               state <= ST_HOLD;
            end
         end else if (acc) begin
            if (found) out_idx <= pick_idx;
            else begin
               out_valid <= 1'b0;
               state <= ST_IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_prio_encoder_hs.sv
// tb_prio_encoder_hs: directed self-checking bench for prio_encoder_hs with N_IN=8.
module tb_prio_encoder_hs;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_i = '0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [2:0] out_idx;
   logic [7:0] out_onehot;
   logic [7:0] pend_o;
   int checks = 0;
   int errors = 0;

   prio_encoder_hs #(.N_IN(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_onehot(out_onehot),
      .pend_o    (pend_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [2:0] i,
                          input logic [7:0] oh, input logic [7:0] p);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".idx"}, 32'(out_idx), 32'(i));
      chk({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
      chk({tag, ".pend"}, 32'(pend_o), 32'(p));
   endtask

   initial begin
      int n;
      repeat (2) step();
      chk_all("reset", 0, 0, 8'h00, 8'h00);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk_all("idle", 0, 0, 8'h00, 8'h00);
      end
      // single pulse, held under back-pressure
      req_i = 8'h20;
      step();
      req_i = 8'h00;
      chk_all("pulse_t1", 0, 0, 8'h00, 8'h20);
      step();
      chk_all("pulse_t2", 1, 5, 8'h20, 8'h20);
      for (int k = 0; k < 20; k++) begin
         step();
         chk_all("hold", 1, 5, 8'h20, 8'h20);
      end
      out_ready = 1'b1;
      step();
      chk_all("acc5", 0, 5, 8'h00, 8'h00);
      // back-to-back grants 2,5,7
      req_i = 8'hA4;
      step();
      req_i = 8'h00;
      chk_all("a4_t1", 0, 5, 8'h00, 8'hA4);
      step();
      chk_all("a4_idx2", 1, 2, 8'h04, 8'hA4);
      step();
      chk_all("a4_idx5", 1, 5, 8'h20, 8'hA0);
      step();
      chk_all("a4_idx7", 1, 7, 8'h80, 8'h80);
      step();
      chk_all("a4_done", 0, 7, 8'h00, 8'h00);
      // re-request of the accepted bit wins over its clear
      out_ready = 1'b0;
      req_i = 8'h08;
      step();
      req_i = 8'h00;
      step();
      chk_all("h3", 1, 3, 8'h08, 8'h08);
      req_i = 8'h02;
      step();
      chk_all("h3_b1", 1, 3, 8'h08, 8'h0A);
      req_i = 8'h08;
      out_ready = 1'b1;
      step();
      req_i = 8'h00;
      chk_all("rereq_idx1", 1, 1, 8'h02, 8'h0A);
      step();
      chk_all("rereq_idx3", 1, 3, 8'h08, 8'h08);
      step();
      chk_all("rereq_done", 0, 3, 8'h00, 8'h00);
      // all-ones held with out_ready high
      req_i = 8'hFF;
      step();
      chk_all("ff_t1", 0, 3, 8'h00, 8'hFF);
      for (int k = 0; k < 9; k++) begin
         logic [2:0] e;
`ifdef ROUND_ROBIN_EN
         e = 3'(k % 8);
`else
         // the just-accepted bit is masked for the reload, so fixed mode alternates 0,1
         e = 3'(k % 2);
`endif
         step();
         chk("ff_valid", 32'(out_valid), 32'd1);
         chk("ff_idx", 32'(out_idx), 32'(e));
      end
      req_i = 8'h00;
      n = 0;
      while (out_valid && n < 20) begin
         step();
         n++;
      end
      chk("ff_drain", 32'(out_valid), 32'd0);
      chk("ff_drain_pend", 32'(pend_o), 32'h00);
      // asynchronous reset mid-handshake
      out_ready = 1'b0;
      req_i = 8'h81;
      step();
      req_i = 8'h00;
      step();
      chk_all("pre_rst", 1, 0, 8'h01, 8'h81);
      #2 rst = 1'b1;
      #1;
      chk_all("async_rst", 0, 0, 8'h00, 8'h00);
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_all("post_rst", 0, 0, 8'h00, 8'h00);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
